video_stream_gen: RTL and testbench

//  Frame-timing and test-pattern source. Drives the vsync/href/clken/pixel stream consumed by
//  the 3x3 window / edge-detection pipeline in place of the camera capture path.

---
 rtl/video_stream_gen.sv | 201 ++++++++++++++++++++
 tb/tb_video_stream_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_gen.sv
// Frame-timing and test-pattern source emitting a camera-style vsync/href/clken/pixel stream.
// Optional build macro VIDEO_STREAM_GEN_FRAME_CNT_EN adds a frame counter port and a moving ramp.
`timescale 1ns/1ps

module video_stream_gen #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_BLANK    = 160,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned CLKEN_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic                  out_frame_vsync,
  output logic                  out_frame_href,
  output logic                  out_frame_clken,
  output logic [DATA_WIDTH-1:0] out_img_y,
  output logic                  busy
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  ,
  output logic [7:0]            frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_MAX01 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned V_MAX23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned V_MAX   = (V_MAX01 > V_MAX23) ? V_MAX01 : V_MAX23;
  localparam int unsigned DIV_W   = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;
  localparam int unsigned X_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned LINE_W  = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          pat_q, pat_d;

  logic                slot_end, line_end, last_line, frame_end;
  int unsigned         cur_lines;

  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic                clken_q, clken_d;
  logic                busy_q, busy_d;
  logic [DATA_WIDTH-1:0] img_q, img_d;
  logic [DATA_WIDTH-1:0] pix;
  logic [DATA_WIDTH-1:0] ramp_ofs;
  logic                checker_bit;

`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
`endif

  // State register and counters.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      x_q     <= '0;
      line_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    case (state_q)
      S_VSYNC:  cur_lines = V_SYNC;
      S_VBACK:  cur_lines = V_BACK;
      S_ACTIVE: cur_lines = V_ACTIVE;
      S_VFRONT: cur_lines = V_FRONT;
      default:  cur_lines = 1;
    endcase
  end

  assign slot_end  = (div_q == DIV_W'(CLKEN_DIV - 1));
  assign line_end  = slot_end && (x_q == X_W'(H_TOTAL - 1));
  assign last_line = (32'(line_q) == cur_lines - 1);

  // Next-state logic.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    x_d       = x_q;
    line_d    = line_q;
    pat_d     = pat_q;
    frame_end = 1'b0;

    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d = S_VSYNC;
        pat_d   = pattern_sel;
      end
    end else begin
      div_d = slot_end ? '0 : div_q + 1'b1;
      if (slot_end) begin
        x_d = (x_q == X_W'(H_TOTAL - 1)) ? '0 : x_q + 1'b1;
      end
      if (line_end) begin
        if (last_line) begin
          line_d = '0;
          case (state_q)
            S_VSYNC:  state_d = (V_BACK == 0) ? S_ACTIVE : S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: begin
              if (V_FRONT == 0) frame_end = 1'b1;
              else              state_d   = S_VFRONT;
            end
            default:  frame_end = 1'b1;
          endcase
        end else begin
          line_d = line_q + 1'b1;
        end
      end
      // Back-to-back frames relatch the pattern with no idle gap.
      if (frame_end) begin
        if (enable) begin
          state_d = S_VSYNC;
          pat_d   = pattern_sel;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  assign frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
  assign ramp_ofs  = DATA_WIDTH'(frame_cnt_q);
`else
  assign ramp_ofs  = '0;
`endif

  // Output decode works on next-state values so registered outputs line up with the state.
  always_comb begin
    checker_bit = |(((32'(x_d) >> 3) ^ (32'(line_d) >> 3)) & 32'd1);
    case (pat_d)
      2'd0:    pix = DATA_WIDTH'(x_d) + ramp_ofs;
      2'd1:    pix = DATA_WIDTH'(line_d) + ramp_ofs;
      2'd2:    pix = checker_bit ? '1 : '0;
      default: pix = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endcase

    vsync_d = (state_d == S_VSYNC);
    busy_d  = (state_d != S_IDLE);
    href_d  = (state_d == S_ACTIVE) && (32'(x_d) < H_ACTIVE);
    clken_d = href_d && (div_d == '0);
    img_d   = clken_d ? pix : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      busy_q  <= 1'b0;
      img_q   <= '0;
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
      clken_q <= clken_d;
      busy_q  <= busy_d;
      img_q   <= img_d;
    end
  end

  assign out_frame_vsync = vsync_q;
  assign out_frame_href  = href_q;
  assign out_frame_clken = clken_q;
  assign out_img_y       = img_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen: cycle-indexed timing model plus a pixel scoreboard.
// Also covers the optional VIDEO_STREAM_GEN_FRAME_CNT_EN build when that macro is defined.
`timescale 1ns/1ps

module tb_video_stream_gen;

  localparam int DW        = 16;
  localparam int HA        = 4;
  localparam int HB        = 2;
  localparam int VS        = 1;
  localparam int VB        = 1;
  localparam int VA        = 3;
  localparam int VF        = 1;
  localparam int DIV       = 2;
  localparam int HT        = HA + HB;
  localparam int LINE_CLK  = HT * DIV;
  localparam int FRAME_CLK = (VS + VB + VA + VF) * LINE_CLK;
  localparam int FRAME1    = (VS + VB + VA + VF) * HT;
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          out_frame_vsync, out_frame_href, out_frame_clken, busy;
  logic [DW-1:0] out_img_y;
  logic          vsync1, href1, clken1, busy1;
  logic [DW-1:0] img1;
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  logic [7:0]    frame_cnt0, frame_cnt1;
`endif

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] sb[$];
  int            t1;

  always #5 clk = ~clk;

  video_stream_gen #(
    .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
    .V_ACTIVE(VA), .V_FRONT(VF), .CLKEN_DIV(DIV)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .out_frame_vsync(out_frame_vsync), .out_frame_href(out_frame_href),
    .out_frame_clken(out_frame_clken), .out_img_y(out_img_y), .busy(busy)
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    , .frame_cnt(frame_cnt0)
`endif
  );

  video_stream_gen #(
    .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
    .V_ACTIVE(VA), .V_FRONT(VF), .CLKEN_DIV(1)
  ) u_dut_div1 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .pattern_sel(2'd0),
    .out_frame_vsync(vsync1), .out_frame_href(href1),
    .out_frame_clken(clken1), .out_img_y(img1), .busy(busy1)
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    , .frame_cnt(frame_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vsync"}, 32'(out_frame_vsync), 32'd0);
    check({tag, "_href"},  32'(out_frame_href),  32'd0);
    check({tag, "_clken"}, 32'(out_frame_clken), 32'd0);
    check({tag, "_img"},   32'(out_img_y),       32'd0);
    check({tag, "_busy"},  32'(busy),            32'd0);
  endtask

  function automatic logic [DW-1:0] exp_pix(input int mode, input int f, input int x, input int l);
    logic [DW-1:0] fc;
    fc = FC_EN ? DW'(f % 256) : '0;
    case (mode)
      0:       return DW'(x) + fc;
      1:       return DW'(l) + fc;
      2:       return ((((x >> 3) ^ (l >> 3)) & 1) != 0) ? '1 : '0;
      default: return {1'b0, {(DW-1){1'b1}}};
    endcase
  endfunction

  // Runs one frame from its first cycle (t=0 is the cycle after the start edge).
  task automatic run_frame(input int mode, input int f, input int chg_t, input logic [1:0] new_sel,
                           input int en_off_t, input int abort_t);
    int row, w, slot, ph;
    bit act, ehref;
    for (int l = 0; l < VA; l++)
      for (int x = 0; x < HA; x++)
        sb.push_back(exp_pix(mode, f, x, l));
    for (int t = 0; t < FRAME_CLK; t++) begin
      row   = t / LINE_CLK;
      w     = t % LINE_CLK;
      slot  = w / DIV;
      ph    = w % DIV;
      act   = (row >= VS + VB) && (row < VS + VB + VA);
      ehref = act && (slot < HA);
      check("vsync", 32'(out_frame_vsync), 32'(row < VS));
      check("href",  32'(out_frame_href),  32'(ehref));
      check("clken", 32'(out_frame_clken), 32'(ehref && (ph == 0)));
      check("busy",  32'(busy),            32'd1);
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
      if (t == 0) check("frame_cnt", 32'(frame_cnt0), 32'(f % 256));
`endif
      if (t == abort_t) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        sb.delete();
        return;
      end
      if (t == chg_t)    pattern_sel = new_sel;
      if (t == en_off_t) enable = 1'b0;
      step();
    end
  endtask

  // Pixel scoreboard for the main instance, cycle model for the CLKEN_DIV=1 instance.
  always @(negedge clk) begin
    int k, w1, row1, slot1;
    bit h1;
    if (!rst_n) begin
      t1 = 0;
    end else begin
      if (out_frame_clken) begin
        if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
        else                check("pixel", 32'(out_img_y), 32'(sb.pop_front()));
      end else begin
        check("pixel_blank", 32'(out_img_y), 32'd0);
      end

      k     = t1 / FRAME1;
      w1    = t1 % FRAME1;
      row1  = w1 / HT;
      slot1 = w1 % HT;
      h1    = (row1 >= VS + VB) && (row1 < VS + VB + VA) && (slot1 < HA);
      check("div1_vsync", 32'(vsync1), 32'(row1 < VS));
      check("div1_href",  32'(href1),  32'(h1));
      check("div1_clken", 32'(clken1), 32'(h1));
      check("div1_busy",  32'(busy1),  32'd1);
      check("div1_pixel", 32'(img1), h1 ? 32'(exp_pix(0, k, slot1, 0)) : 32'd0);
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
      if (w1 == 0) check("div1_frame_cnt", 32'(frame_cnt1), 32'(k % 256));
`endif
      t1++;
    end
  end

  initial begin
    enable      = 1'b1;
    pattern_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    run_frame(0, 0, 40, 2'd3, -1, -1);
    run_frame(3, 1, 10, 2'd1, -1, -1);
    run_frame(1, 2, 20, 2'd2, 30, -1);

    for (int i = 0; i < 20; i++) begin
      check("idle_vsync", 32'(out_frame_vsync), 32'd0);
      check("idle_href",  32'(out_frame_href),  32'd0);
      check("idle_busy",  32'(busy),            32'd0);
      step();
    end

    enable = 1'b1;
    step();
    run_frame(2, 3, -1, 2'd0, 5, -1);
    for (int i = 0; i < 5; i++) begin
      check("idle2_busy", 32'(busy), 32'd0);
      step();
    end

    enable      = 1'b1;
    pattern_sel = 2'd0;
    step();
    run_frame(0, 4, -1, 2'd0, -1, 30);
    @(negedge clk);
    check_all_zero("held_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    run_frame(0, 0, -1, 2'd0, 60, -1);

    check("end_busy", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
